instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Program-counter and instruction-register unit feeding the PIC16F instruction decoder. It holds the 13-bit PC, drives the program-memory address, latches fetched words into `instr_current`, and applies the decoder's increment, jump, flush and read requests. It also owns the 8-level hardware return stack and the PCL-write (computed goto) path. It sits between program memory and the instruction decoder; all control inputs come from the decoder or the file-register write path.

## Interface
Parameters:
- STACK_DEPTH, 8: return-stack entries; must be a power of 2.
- NOP_WORD, 14'h0000: word loaded into `instr_current` on flush and reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- instr_rd_en  in  1  load `pgm_data` into `instr_current`.
- instr_flush  in  1  load NOP_WORD into `instr_current`.
- pc_incr_en  in  1  PC <= PC+1.
- pc_j_en  in  1  goto: PC <= {pclath[4:3], instr_current[10:0]}.
- pc_call_en  in  1  push PC, then jump as for goto.
- pc_ret_en  in  1  PC <= top of stack, pop.
- pcl_wr_en  in  1  computed goto: PC <= {pclath[4:0], pcl_wr_data}.
- pcl_wr_data  in  8  new PCL value.
- pclath  in  5  PCLATH register contents.
- pgm_addr  out  13  program-memory address, combinationally equal to PC.
- pgm_data  in  14  program-memory read data; synchronous memory, valid 1 cycle after `pgm_addr` changes.
- instr_current  out  14  registered instruction presented to the decoder.
- pc  out  13  current PC.
- stack_ptr  out  3  stack pointer (debug).

## Operation
- PC points at the next instruction to be loaded, not the one executing. Execution of A overlaps with the fetch of A+1.
- `instr_current` update priority: rst > instr_flush > instr_rd_en > hold.
- PC update priority (one action per cycle): rst > pc_ret_en > pc_call_en > pc_j_en > pcl_wr_en > pc_incr_en > hold.
- Call pushes the current PC. Because the PC already holds the address after the call, no +1 is needed. Call and jump targets use `instr_current` sampled in the same cycle.
- Stack push:
  - Write mem[sp], then sp <= sp+1 mod 8.
  - On overflow the pointer wraps and the oldest entry is overwritten silently, with no flag.
- Stack pop:
  - sp <= sp-1 mod 8, PC <= mem[sp-1].
  - Underflow wraps silently and returns stale contents.
- Arithmetic: PC+1 is 13-bit and wraps 13'h1FFF -> 13'h0000. Targets are formed by concatenation only; no carry into the PCLATH bits.
- Inputs that are not the selected action are ignored in that cycle. For example, call together with incr does not increment.
- The stack does not change on anything except call and ret.

## Timing
- Reset values: pc = 0, pgm_addr = 0, instr_current = NOP_WORD, stack_ptr = 0. Stack contents are not reset.
- After reset the decoder executes the NOP_WORD. At its Q3 it asserts rd+incr, which loads the word at address 0 and sets PC to 1. Effective reset vector: 0.
- The PC holds for at least 3 cycles between updates, so `pgm_data` is valid by the next rd_en.
- `instr_current` and PC change on the same clock edge in which the controls are sampled. There is no combinational path from the controls to the outputs except `pgm_addr` = PC.
- Goto/call sequence:
  - At Q3 the decoder asserts flush + j/call.
  - On that edge `instr_current` becomes NOP and PC becomes the target.
  - The NOP's Q3 loads the target instruction. The total branch cost is 8 clocks.
- Reset asserted mid-sequence overrides every other input on that edge. There is no partial push.

## Structure
- Shared header `isa.vh` holds: NOP_WORD value, PC width (13), instruction width (14), goto literal field [10:0], PCLATH select [4:3].
- One sub-module, `call_stack`:
  - Circular 8x13 register file with a 3-bit pointer.
  - Ports: push, pop, push_data, pop_data, sp.
  - Owns the wrap behaviour.

## Test plan
- Reset, then 4-cycle Q pattern of rd+incr with memory[0..2] = 14'h3005, 14'h0000, 14'h3007 -> `instr_current` = 14'h3005, 14'h0000, 14'h3007 on successive Q3 edges; PC = 1, 2, 3.
- instr_current = 14'h2A34 (goto 0x234), pclath = 5'b01000, flush + pc_j_en -> instr_current = 0, PC = 13'h0A34.
- 9 calls from PC values 0x10..0x18, then 9 rets -> rets return 0x18, 0x17 … 0x11, then 0x18 again (overwritten wrap); stack_ptr ends at 0.
- PC = 13'h1FFF, pc_incr_en -> PC = 0. pcl_wr_en with data 8'hC3, pclath 5'h12 -> PC = 13'h12C3.
- pc_ret_en, pc_call_en, pc_j_en and pc_incr_en asserted together -> only ret applied; flush together with rd_en -> instr_current = NOP.
- rst asserted in the same cycle as a call -> PC = 0 and stack_ptr = 0.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: ISA widths, reset word, PC action encoding and branch target helpers
package instruction_fetch_pkg;
  localparam int PC_W = 13;
  localparam int INSTR_W = 14;
  localparam int PCLATH_W = 5;
  localparam logic [INSTR_W-1:0] NOP_DEFAULT = 14'h0000;
  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INCR,
    PC_PCL,
    PC_JUMP,
    PC_CALL,
    PC_RET
  } pc_op_e;
  function automatic logic [PC_W-1:0] goto_target(input logic [PCLATH_W-1:0] pclath, input logic [INSTR_W-1:0] instr);
    return {pclath[4:3], instr[10:0]};
  endfunction
  function automatic logic [PC_W-1:0] pcl_target(input logic [PCLATH_W-1:0] pclath, input logic [7:0] data);
    return {pclath, data};
  endfunction
endpackage

// File: rtl/instruction_fetch_call_stack.sv
// call_stack: circular return-address file; pointer wraps silently on overflow and underflow
module call_stack
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int SW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] pop_data,
  output logic [SW-1:0]   sp
);
  logic [PC_W-1:0] mem [DEPTH];
  logic [SW-1:0] sp_dec;
  always_comb begin
    sp_dec = sp - SW'(1);
    pop_data = mem[sp_dec];
  end
  always_ff @(posedge clk) begin
    if (rst) sp <= '0;
    else if (pop) sp <= sp_dec;
    else if (push) sp <= sp + SW'(1);
  end
  // contents are never reset; a push coinciding with reset is dropped entirely
  always_ff @(posedge clk) begin
    if (push && !pop && !rst) mem[sp] <= push_data;
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, instruction register and return stack feeding the PIC16F decoder
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter logic [INSTR_W-1:0] NOP_WORD = NOP_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           instr_rd_en,
  input  logic                           instr_flush,
  input  logic                           pc_incr_en,
  input  logic                           pc_j_en,
  input  logic                           pc_call_en,
  input  logic                           pc_ret_en,
  input  logic                           pcl_wr_en,
  input  logic [7:0]                     pcl_wr_data,
  input  logic [PCLATH_W-1:0]            pclath,
  output logic [PC_W-1:0]                pgm_addr,
  input  logic [INSTR_W-1:0]             pgm_data,
  output logic [INSTR_W-1:0]             instr_current,
  output logic [PC_W-1:0]                pc,
  output logic [$clog2(STACK_DEPTH)-1:0] stack_ptr
);
  pc_op_e op;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] ret_addr;
  always_comb begin
    op = pc_ret_en ? PC_RET :
         pc_call_en ? PC_CALL :
         pc_j_en ? PC_JUMP :
         pcl_wr_en ? PC_PCL :
         pc_incr_en ? PC_INCR : PC_HOLD;
    pc_next = (op == PC_RET) ? ret_addr :
              (op == PC_CALL || op == PC_JUMP) ? goto_target(pclath, instr_current) :
              (op == PC_PCL) ? pcl_target(pclath, pcl_wr_data) :
              (op == PC_INCR) ? pc + PC_W'(1) : pc;
  end
  assign pgm_addr = pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      instr_current <= NOP_WORD;
    end else begin
      pc <= pc_next;
      instr_current <= instr_flush ? NOP_WORD : instr_rd_en ? pgm_data : instr_current;
    end
  end
  // the PC already points past the call, so it is pushed as-is
  call_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (op == PC_CALL),
    .pop      (op == PC_RET),
    .push_data(pc),
    .pop_data (ret_addr),
    .sp       (stack_ptr)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and random stimulus checked by a queue scoreboard against a reference model
module tb_instruction_fetch;
  localparam logic [13:0] NOP = 14'h0000;
  typedef struct packed {
    logic r, rd, fl, inc, j, call, ret, pw;
    logic [7:0] pwd;
    logic [4:0] plth;
  } ctl_t;
  typedef struct packed {
    logic [12:0] pc;
    logic [13:0] ins;
    logic [2:0] sp;
  } exp_t;
  logic clk = 0, rst = 1;
  logic instr_rd_en = 0, instr_flush = 0, pc_incr_en = 0, pc_j_en = 0, pc_call_en = 0, pc_ret_en = 0, pcl_wr_en = 0;
  logic [7:0] pcl_wr_data = 0;
  logic [4:0] pclath = 0;
  logic [12:0] pgm_addr, pc;
  logic [13:0] pgm_data, instr_current;
  logic [2:0] stack_ptr;
  logic [13:0] rom [8192];
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  int m_pc = 0, m_sp = 0;
  int m_mem [8];
  logic [13:0] m_ins = NOP, m_pd = 0;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .instr_rd_en(instr_rd_en), .instr_flush(instr_flush),
    .pc_incr_en(pc_incr_en), .pc_j_en(pc_j_en), .pc_call_en(pc_call_en), .pc_ret_en(pc_ret_en),
    .pcl_wr_en(pcl_wr_en), .pcl_wr_data(pcl_wr_data), .pclath(pclath), .pgm_addr(pgm_addr),
    .pgm_data(pgm_data), .instr_current(instr_current), .pc(pc), .stack_ptr(stack_ptr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pgm_data <= rom[pgm_addr];

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc", {1'b0, pc}, {1'b0, e.pc});
      chk("pgm_addr", {1'b0, pgm_addr}, {1'b0, e.pc});
      chk("instr_current", instr_current, e.ins);
      chk("stack_ptr", {11'b0, stack_ptr}, {11'b0, e.sp});
    end
  end

  task automatic step(input ctl_t c);
    int nxt, jmp;
    logic [13:0] nins;
    exp_t e;
    @(negedge clk);
    rst = c.r; instr_rd_en = c.rd; instr_flush = c.fl; pc_incr_en = c.inc; pc_j_en = c.j;
    pc_call_en = c.call; pc_ret_en = c.ret; pcl_wr_en = c.pw; pcl_wr_data = c.pwd; pclath = c.plth;
    jmp = int'(c.plth) / 8 * 2048 + int'(m_ins) % 2048;
    nxt = m_pc;
    nins = m_ins;
    if (c.r) begin
      nxt = 0; nins = NOP; m_sp = 0;
    end else begin
      if (c.ret) begin m_sp = (m_sp + 7) % 8; nxt = m_mem[m_sp]; end
      else if (c.call) begin m_mem[m_sp] = m_pc; m_sp = (m_sp + 1) % 8; nxt = jmp; end
      else if (c.j) nxt = jmp;
      else if (c.pw) nxt = int'(c.plth) * 256 + int'(c.pwd);
      else if (c.inc) nxt = (m_pc + 1) % 8192;
      nins = c.fl ? NOP : c.rd ? m_pd : m_ins;
    end
    m_pd = rom[m_pc];
    m_pc = nxt;
    m_ins = nins;
    e.pc = 13'(m_pc); e.ins = m_ins; e.sp = 3'(m_sp);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    ctl_t c;
    c = '0;
    for (int i = 0; i < n; i++) step(c);
  endtask

  task automatic pcl(input logic [4:0] lath, input logic [7:0] d);
    ctl_t c;
    c = '0; c.pw = 1; c.plth = lath; c.pwd = d;
    step(c);
  endtask

  initial begin
    ctl_t c;
    for (int i = 0; i < 8192; i++) rom[i] = 14'($urandom);
    rom[0] = 14'h3005; rom[1] = 14'h0000; rom[2] = 14'h3007;
    rom[13'h040] = 14'h2A34;
    c = '0; c.r = 1;
    step(c); step(c);
    for (int k = 0; k < 3; k++) begin
      idle(3);
      c = '0; c.rd = 1; c.inc = 1; step(c);
    end
    pcl(5'h00, 8'h40); idle(3);
    c = '0; c.rd = 1; step(c);
    c = '0; c.fl = 1; c.j = 1; c.plth = 5'b01000; step(c);
    for (int i = 0; i < 9; i++) begin
      pcl(5'h00, 8'(8'h10 + i));
      c = '0; c.call = 1; c.fl = 1; step(c);
    end
    for (int i = 0; i < 9; i++) begin
      c = '0; c.ret = 1; step(c); idle(1);
    end
    pcl(5'h1F, 8'hFF);
    c = '0; c.inc = 1; step(c);
    pcl(5'h12, 8'hC3);
    c = '0; c.ret = 1; c.call = 1; c.j = 1; c.inc = 1; step(c);
    idle(2);
    c = '0; c.fl = 1; c.rd = 1; step(c);
    pcl(5'h03, 8'h21); idle(2);
    c = '0; c.call = 1; c.r = 1; step(c);
    idle(2);
    for (int i = 0; i < 600; i++) begin
      c.r = ($urandom_range(63) == 0);
      c.rd = ($urandom_range(3) == 0);
      c.fl = ($urandom_range(7) == 0);
      c.inc = ($urandom_range(2) == 0);
      c.j = ($urandom_range(9) == 0);
      c.call = ($urandom_range(9) == 0);
      c.ret = ($urandom_range(9) == 0);
      c.pw = ($urandom_range(9) == 0);
      c.pwd = 8'($urandom);
      c.plth = 5'($urandom);
      step(c);
    end
    idle(1);
    @(posedge clk);
    #3;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
